// File: rtl/rv_data_bus_demux.sv
// rv_data_bus_demux: fans one core data port out to N_SLV base/mask windows, routes responses in order.
// Optional macro RV_BUS_TIMEOUT_EN: force an error response when a mapped slave never answers.

module rv_data_bus_demux #(
  parameter int unsigned           XLEN        = 32,
  parameter int unsigned           N_SLV       = 4,
  parameter logic [N_SLV*XLEN-1:0] SLV_BASE    = {32'h8000_1000, 32'h8000_0000,
                                                  32'h0001_0000, 32'h0000_0000},
  parameter logic [N_SLV*XLEN-1:0] SLV_MASK    = {32'hFFFF_F000, 32'hFFFF_F000,
                                                  32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned           MAX_OUTST   = 2,
  parameter int unsigned           TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic                    data_we_i,
  input  logic [XLEN/8-1:0]       data_be_i,
  input  logic [XLEN-1:0]         data_addr_i,
  input  logic [XLEN-1:0]         data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [XLEN-1:0]         data_rdata_o,
  output logic                    data_err_o,
  output logic [N_SLV-1:0]        slv_req_o,
  output logic                    slv_we_o,
  output logic [XLEN/8-1:0]       slv_be_o,
  output logic [XLEN-1:0]         slv_addr_o,
  output logic [XLEN-1:0]         slv_wdata_o,
  input  logic [N_SLV-1:0]        slv_rvalid_i,
  input  logic [N_SLV*XLEN-1:0]   slv_rdata_i,
  output logic                    spurious_o
);

  localparam int unsigned SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  // FIFO entry: {unmapped, sel}
  logic [SEL_W:0]     fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_pend_q, err_pend_d;
  logic               spurious_q, spurious_d;

  logic               hit;
  logic [SEL_W-1:0]   sel;
  logic [XLEN-1:0]    sel_base;
  logic [N_SLV-1:0]   sel_oh;
  logic               head_unm;
  logic [SEL_W-1:0]   head_sel;
  logic [XLEN-1:0]    head_rdata;
  logic [N_SLV-1:0]   head_oh;
  logic               empty, full;
  logic               head_mapped_vld;
  logic               head_rv;
  logic               tmo_fire;
  logic               pop, push;
  logic [CNT_W-1:0]   remain;
  logic               nxt_head_unm;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Descending scan so the lowest matching index is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((data_addr_i & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

  assign head_unm = fifo_q[rd_ptr_q][SEL_W];
  assign head_sel = fifo_q[rd_ptr_q][SEL_W-1:0];

  always_comb begin
    sel_base   = '0;
    sel_oh     = '0;
    head_rdata = '0;
    head_oh    = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_base  = SLV_BASE[i*XLEN +: XLEN];
        sel_oh[i] = 1'b1;
      end
      if (head_sel == SEL_W'(i)) begin
        head_rdata = slv_rdata_i[i*XLEN +: XLEN];
        head_oh[i] = 1'b1;
      end
    end
  end

  assign empty           = (cnt_q == '0);
  assign full            = (cnt_q == CNT_W'(MAX_OUTST));
  assign head_mapped_vld = !empty && !head_unm;
  assign head_rv         = head_mapped_vld && |(slv_rvalid_i & head_oh);

`ifdef RV_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Down-counter reloads whenever the head changes or is not a waiting mapped entry.
  always_comb begin
    if (pop || !head_mapped_vld) tmo_d = TMO_W'(TIMEOUT_CYC - 1);
    else if (tmo_q != '0)        tmo_d = tmo_q - 1'b1;
    else                         tmo_d = tmo_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
    else         tmo_q <= tmo_d;
  end

  assign tmo_fire = head_mapped_vld && !head_rv && (tmo_q == '0);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_fire   = 1'b0;
`endif

  // err_pend_q is only ever set while an unmapped entry sits at the head.
  assign pop  = err_pend_q | head_rv | tmo_fire;
  assign push = data_gnt_o;

  assign data_gnt_o    = data_req_i & (~full | pop);
  assign slv_req_o     = (data_gnt_o && hit) ? sel_oh : '0;
  assign slv_we_o      = data_we_i;
  assign slv_be_o      = data_be_i;
  assign slv_wdata_o   = data_wdata_i;
  assign slv_addr_o    = hit ? (data_addr_i - sel_base) : '0;

  assign data_rvalid_o = pop;
  assign data_err_o    = err_pend_q | tmo_fire;
  assign data_rdata_o  = head_rv ? head_rdata : '0;
  assign spurious_o    = spurious_q;

  always_comb begin
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    remain     = cnt_q - CNT_W'(pop);
    // The entry at the head next cycle is either a surviving one or the one being pushed now.
    if (remain == '0) nxt_head_unm = push & ~hit;
    else              nxt_head_unm = fifo_q[rd_ptr_d][SEL_W];
    err_pend_d = nxt_head_unm;
    spurious_d = spurious_q | (|(slv_rvalid_i & ~(head_mapped_vld ? head_oh : '0)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_OUTST); i++) fifo_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= {~hit, sel};
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      spurious_q <= spurious_d;
    end
  end

endmodule
